// File: rtl/mem_seq_pkg.sv
// Shared definitions for the Datapath control sequencer: opcodes, state
// encoding, control-bus bit map, fault codes and the per-state control word.
package mem_seq_pkg;

    localparam int OPCODE_W   = 5;
    localparam int CTRL_WIDTH = 20;

    localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OPCODE_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPCODE_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

    // Encoding doubles as the debug T-state number.
    typedef enum logic [3:0] {
        S_T0    = 4'h0,
        S_T1    = 4'h1,
        S_T2    = 4'h2,
        S_T3    = 4'h3,
        S_T4    = 4'h4,
        S_T5    = 4'h5,
        S_T6    = 4'h6,
        S_T7    = 4'h7,
        S_FAULT = 4'hE,
        S_HALT  = 4'hF
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_ILLEGAL = 2'd1,
        FC_TIMEOUT = 2'd2
    } fault_code_t;

    localparam int C_PCOUT     = 0;
    localparam int C_PCIN      = 1;
    localparam int C_MARIN     = 2;
    localparam int C_INCPC     = 3;
    localparam int C_ZLOWIN    = 4;
    localparam int C_ZLOWOUT   = 5;
    localparam int C_MDRIN     = 6;
    localparam int C_MDROUT    = 7;
    localparam int C_MDMUXREAD = 8;
    localparam int C_RAMREAD   = 9;
    localparam int C_RAMWRITE  = 10;
    localparam int C_IRIN      = 11;
    localparam int C_GRB       = 12;
    localparam int C_GRA       = 13;
    localparam int C_BAOUT     = 14;
    localparam int C_RIN       = 15;
    localparam int C_ROUT      = 16;
    localparam int C_YIN       = 17;
    localparam int C_CSEOUT    = 18;
    localparam int C_ADD       = 19;

    function automatic logic [CTRL_WIDTH-1:0] ctrl_word(state_t s, logic [OPCODE_W-1:0] op);
        logic [CTRL_WIDTH-1:0] w;
        w = '0;
        case (s)
            S_T0: begin
                w[C_PCOUT] = 1'b1; w[C_MARIN] = 1'b1; w[C_INCPC] = 1'b1; w[C_ZLOWIN] = 1'b1;
            end
            S_T1: begin
                w[C_ZLOWOUT] = 1'b1; w[C_PCIN] = 1'b1; w[C_MDMUXREAD] = 1'b1;
                w[C_RAMREAD] = 1'b1; w[C_MDRIN] = 1'b1;
            end
            S_T2: begin
                w[C_MDROUT] = 1'b1; w[C_IRIN] = 1'b1;
            end
            S_T3: begin
                if (op == OP_LD || op == OP_LDI || op == OP_ST) begin
                    w[C_GRB] = 1'b1; w[C_BAOUT] = 1'b1; w[C_YIN] = 1'b1;
                end
            end
            S_T4: begin
                w[C_CSEOUT] = 1'b1; w[C_ADD] = 1'b1; w[C_ZLOWIN] = 1'b1;
            end
            S_T5: begin
                w[C_ZLOWOUT] = 1'b1;
                if (op == OP_LDI) begin
                    w[C_GRA] = 1'b1; w[C_RIN] = 1'b1;
                end else begin
                    w[C_MARIN] = 1'b1;
                end
            end
            S_T6: begin
                if (op == OP_ST) begin
                    w[C_GRA] = 1'b1; w[C_ROUT] = 1'b1; w[C_RAMWRITE] = 1'b1;
                end else begin
                    w[C_MDMUXREAD] = 1'b1; w[C_RAMREAD] = 1'b1; w[C_MDRIN] = 1'b1;
                end
            end
            S_T7: begin
                w[C_MDROUT] = 1'b1; w[C_GRA] = 1'b1; w[C_RIN] = 1'b1;
            end
            default: ;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on RAM and flags when the wait budget is used up.
module mem_wait_timer #(
    parameter int TIMEOUT = 15,
    parameter int CW      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1)
) (
    input  logic clock,
    input  logic clear,
    input  logic enable,
    input  logic restart,
    output logic expired
);

    logic [CW-1:0] count;

    // Saturates so a disabled timeout can never wrap back to a small value.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear)
            count <= '0;
        else if (restart)
            count <= '0;
        else if (enable && count != '1)
            count <= count + 1'b1;
    end

    assign expired = (TIMEOUT != 0) && (count == CW'(TIMEOUT));

endmodule

// File: rtl/mem_seq_ctrl.sv
// Hardwired T-state sequencer driving the Datapath control bus, with RAM
// wait states, wait timeout, illegal-opcode fault and halt.
module mem_seq_ctrl
    import mem_seq_pkg::*;
#(
    parameter int OPW     = OPCODE_W,
    parameter int CTRL_W  = CTRL_WIDTH,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [OPW-1:0]    ir_opcode,
    input  logic              mem_ready,
    output logic [CTRL_W-1:0] ctrl,
    output logic              run,
    output logic              fault,
    output logic [1:0]        fault_code,
    output logic [3:0]        tstate
);

    state_t            state, state_next;
    fault_code_t       fc_q, fc_next;
    logic [OPW-1:0]    op_q, op_sel;
    logic [CTRL_W-1:0] ctrl_next;
    logic              mem_state, wait_en, expired;

    assign mem_state = (state == S_T1) || (state == S_T6);
    assign wait_en   = mem_state && !mem_ready;

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock   (clock),
        .clear   (clear),
        .enable  (wait_en),
        .restart (!wait_en),
        .expired (expired)
    );

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= S_T0;
            ctrl  <= '0;
            fc_q  <= FC_NONE;
            op_q  <= '0;
        end else begin
            state <= state_next;
            ctrl  <= ctrl_next;
            fc_q  <= fc_next;
            if (state == S_T3)
                op_q <= ir_opcode;
        end
    end

    // NOTE: defaults first so no path through the case can infer a latch.
    always_comb begin
        state_next = state;
        fc_next    = fc_q;
        case (state)
            S_T0: state_next = S_T1;
            S_T1: begin
                if (expired) begin
                    state_next = S_FAULT;
                    fc_next    = FC_TIMEOUT;
                end else if (mem_ready) begin
                    state_next = S_T2;
                end
            end
            S_T2: state_next = S_T3;
            S_T3: begin
                case (ir_opcode)
                    OP_LD, OP_LDI, OP_ST: state_next = S_T4;
                    OP_NOP:               state_next = S_T0;
                    OP_HALT:              state_next = S_HALT;
                    default: begin
                        state_next = S_FAULT;
                        fc_next    = FC_ILLEGAL;
                    end
                endcase
            end
            S_T4: state_next = S_T5;
            S_T5: state_next = (op_q == OP_LDI) ? S_T0 : S_T6;
            S_T6: begin
                if (expired) begin
                    state_next = S_FAULT;
                    fc_next    = FC_TIMEOUT;
                end else if (mem_ready) begin
                    state_next = (op_q == OP_LD) ? S_T7 : S_T0;
                end
            end
            S_T7:    state_next = S_T0;
            default: state_next = state;
        endcase
    end

    // The T3 word is looked up while still in T2, so the live opcode is used
    // there; later states use the copy captured in T3.
    always_comb begin
        op_sel     = ((state == S_T2) || (state == S_T3)) ? ir_opcode : op_q;
        ctrl_next  = ctrl_word(state_next, op_sel);
        run        = !((state == S_HALT) || (state == S_FAULT));
        fault      = (state == S_FAULT);
        fault_code = fc_q;
        tstate     = state;
    end

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Directed bench for mem_seq_ctrl: instruction sequences, wait states,
// timeout, illegal opcode, halt and asynchronous reset.
module tb_mem_seq_ctrl;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [4:0]  ir_opcode = 5'b00001;
    logic        mem_ready = 1'b1;
    logic [19:0] ctrl;
    logic        run, fault;
    logic [1:0]  fault_code;
    logic [3:0]  tstate;

    int checks = 0;
    int errors = 0;

    localparam logic [19:0] CT0     = 20'h0001D;
    localparam logic [19:0] CT1     = 20'h00362;
    localparam logic [19:0] CT2     = 20'h00880;
    localparam logic [19:0] CT3     = 20'h25000;
    localparam logic [19:0] CT4     = 20'hC0010;
    localparam logic [19:0] CT5_LDI = 20'h0A020;
    localparam logic [19:0] CT5_MEM = 20'h00024;
    localparam logic [19:0] CT6_LD  = 20'h00340;
    localparam logic [19:0] CT6_ST  = 20'h12400;
    localparam logic [19:0] CT7     = 20'h0A080;

    mem_seq_ctrl #(.TIMEOUT(15)) dut (
        .clock      (clock),
        .clear      (clear),
        .ir_opcode  (ir_opcode),
        .mem_ready  (mem_ready),
        .ctrl       (ctrl),
        .run        (run),
        .fault      (fault),
        .fault_code (fault_code),
        .tstate     (tstate)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_t(input string tag, input logic [3:0] ts, input logic [19:0] c);
        check({tag, ".tstate"}, 32'(tstate), 32'(ts));
        check({tag, ".ctrl"}, 32'(ctrl), 32'(c));
    endtask

    task automatic expect_stopped(input string tag, input logic f, input logic [1:0] code);
        check({tag, ".ctrl"}, 32'(ctrl), 32'h0);
        check({tag, ".run"}, 32'(run), 32'h0);
        check({tag, ".fault"}, 32'(fault), 32'(f));
        check({tag, ".code"}, 32'(fault_code), 32'(code));
    endtask

    // Called just after a rising edge; reset spans a falling edge only.
    task automatic apply_reset(input string tag);
        clear = 1'b0;
        #2;
        expect_t({tag, ".in_reset"}, 4'h0, 20'h0);
        check({tag, ".in_reset.run"}, 32'(run), 32'h1);
        check({tag, ".in_reset.fault"}, 32'(fault), 32'h0);
        check({tag, ".in_reset.code"}, 32'(fault_code), 32'h0);
        #2;
        clear = 1'b1;
        #1;
    endtask

    initial begin
        #2;
        apply_reset("por");

        // ldi: the first T0 after reset still shows the reset ctrl value.
        expect_t("ldi.t0", 4'h0, 20'h0);
        step(); expect_t("ldi.t1", 4'h1, CT1);
        step(); expect_t("ldi.t2", 4'h2, CT2);
        step(); expect_t("ldi.t3", 4'h3, CT3);
        step(); expect_t("ldi.t4", 4'h4, CT4);
        ir_opcode = 5'b11011;
        step(); expect_t("ldi.t5", 4'h5, CT5_LDI);
        step(); expect_t("ldi.t0_next", 4'h0, CT0);
        check("ldi.run", 32'(run), 32'h1);

        ir_opcode = 5'b00010;
        step(); expect_t("st.t1", 4'h1, CT1);
        step(); expect_t("st.t2", 4'h2, CT2);
        step(); expect_t("st.t3", 4'h3, CT3);
        step(); expect_t("st.t4", 4'h4, CT4);
        ir_opcode = 5'b11111;
        step(); expect_t("st.t5", 4'h5, CT5_MEM);
        step(); expect_t("st.t6", 4'h6, CT6_ST);
        step(); expect_t("st.t0_next", 4'h0, CT0);

        ir_opcode = 5'b00000;
        step(); expect_t("ld.t1", 4'h1, CT1);
        step(); expect_t("ld.t2", 4'h2, CT2);
        step(); expect_t("ld.t3", 4'h3, CT3);
        step(); expect_t("ld.t4", 4'h4, CT4);
        step(); expect_t("ld.t5", 4'h5, CT5_MEM);
        mem_ready = 1'b0;
        step(); expect_t("ld.t6_a", 4'h6, CT6_LD);
        step(); expect_t("ld.t6_b", 4'h6, CT6_LD);
        step(); expect_t("ld.t6_c", 4'h6, CT6_LD);
        step(); expect_t("ld.t6_d", 4'h6, CT6_LD);
        mem_ready = 1'b1;
        step(); expect_t("ld.t7", 4'h7, CT7);
        step(); expect_t("ld.t0_next", 4'h0, CT0);

        // nop with 14 held T1 cycles: ready on the last cycle before expiry.
        ir_opcode = 5'b11010;
        step(); expect_t("nop.t1_0", 4'h1, CT1);
        mem_ready = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            step(); expect_t("nop.t1_hold", 4'h1, CT1);
        end
        step(); expect_t("nop.t1_14", 4'h1, CT1);
        mem_ready = 1'b1;
        step(); expect_t("nop.t2", 4'h2, CT2);
        check("nop.fault", 32'(fault), 32'h0);
        step(); expect_t("nop.t3", 4'h3, 20'h0);
        step(); expect_t("nop.t0_next", 4'h0, CT0);

        ir_opcode = 5'b00000;
        step(); expect_t("tmo.t1_0", 4'h1, CT1);
        mem_ready = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            step(); expect_t("tmo.t1_hold", 4'h1, CT1);
        end
        step(); expect_stopped("tmo.fault", 1'b1, 2'd2);
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(); expect_stopped("tmo.sticky", 1'b1, 2'd2);
        end

        apply_reset("rst_fault");
        expect_t("rst_fault.t0", 4'h0, 20'h0);
        check("rst_fault.fault", 32'(fault), 32'h0);

        ir_opcode = 5'b00111;
        step(); expect_t("ill.t1", 4'h1, CT1);
        step(); expect_t("ill.t2", 4'h2, CT2);
        step(); check("ill.t3", 32'(tstate), 32'h3);
        check("ill.t3.fault", 32'(fault), 32'h0);
        step(); expect_stopped("ill.fault", 1'b1, 2'd1);

        apply_reset("rst_ill");
        ir_opcode = 5'b11011;
        step(); expect_t("halt.t1", 4'h1, CT1);
        step(); expect_t("halt.t2", 4'h2, CT2);
        step(); check("halt.t3", 32'(tstate), 32'h3);
        step(); check("halt.tstate", 32'(tstate), 32'hF);
        expect_stopped("halt.entry", 1'b0, 2'd0);
        for (int i = 0; i < 50; i++) begin
            ir_opcode = 5'($urandom);
            mem_ready = 1'($urandom);
            step(); expect_t("halt.hold", 4'hF, 20'h0);
            check("halt.hold.run", 32'(run), 32'h0);
        end

        apply_reset("rst_halt");
        ir_opcode = 5'b00010;
        mem_ready = 1'b1;
        step(); expect_t("rst_st.t1", 4'h1, CT1);
        step(); expect_t("rst_st.t2", 4'h2, CT2);
        step(); expect_t("rst_st.t3", 4'h3, CT3);
        step(); expect_t("rst_st.t4", 4'h4, CT4);
        step(); expect_t("rst_st.t5", 4'h5, CT5_MEM);
        mem_ready = 1'b0;
        step(); expect_t("rst_st.t6", 4'h6, CT6_ST);
        step(); expect_t("rst_st.t6_hold", 4'h6, CT6_ST);
        apply_reset("rst_st");
        expect_t("rst_st.after", 4'h0, 20'h0);
        check("rst_st.after.fault", 32'(fault), 32'h0);
        check("rst_st.after.run", 32'(run), 32'h1);
        mem_ready = 1'b1;
        step(); expect_t("rst_st.restart_t1", 4'h1, CT1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
